// File: rtl/ru_pkg.sv
// Constants shared by the register unit and its dump reader, plus the
// dump reader's state encoding.
package ru_pkg;

  localparam int RU_AW    = 5;
  localparam int RU_DW    = 32;
  localparam int RU_NREGS = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SEND_A = 3'd2,
    ST_SEND_B = 3'd3,
    ST_DONE   = 3'd4
  } ru_dump_state_t;

endpackage

// File: rtl/ru_dump.sv
// Walks x0..x(2**AW-1) two at a time through the RU read ports and streams
// each register value out over a valid/ready handshake.
module ru_dump
  import ru_pkg::*;
#(
  parameter int DW = RU_DW,
  parameter int AW = RU_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rs1,
  output logic [AW-1:0] rs2,
  input  logic [DW-1:0] ruRs1,
  input  logic [DW-1:0] ruRs2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] TWO      = ONE + ONE;
  localparam logic [AW-1:0] THREE    = TWO + ONE;

  ru_dump_state_t state_q;
  logic [AW-1:0]  idx_q;
  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic           busy_q;
  logic           done_q;
  logic [AW-1:0]  rs1_q;
  logic [AW-1:0]  rs2_q;
  logic           valid_q;
  logic [AW-1:0]  oidx_q;
  logic           last_q;
  logic [AW-1:0]  idx_hi_d;

  assign idx_hi_d = idx_q + ONE;

  // Dump sequencer: pair counter, capture registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      valid_q <= 1'b0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_READ;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            rs1_q   <= '0;
            rs2_q   <= ONE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          a_q     <= ruRs1;
          b_q     <= ruRs2;
          rs1_q   <= '0;
          rs2_q   <= '0;
          valid_q <= 1'b1;
          oidx_q  <= idx_q;
          last_q  <= 1'b0;
          state_q <= ST_SEND_A;
        end
        ST_SEND_A: begin
          if (out_ready) begin
            oidx_q  <= idx_hi_d;
            last_q  <= (idx_hi_d == LAST_IDX);
            state_q <= ST_SEND_B;
          end else begin
            state_q <= ST_SEND_A;
          end
        end
        ST_SEND_B: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              // rs1/rs2 are presented already addressed for the next pair
              idx_q   <= idx_q + TWO;
              rs1_q   <= idx_q + TWO;
              rs2_q   <= idx_q + THREE;
              state_q <= ST_READ;
            end
          end else begin
            state_q <= ST_SEND_B;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rs1_q   <= '0;
          rs2_q   <= '0;
          valid_q <= 1'b0;
          oidx_q  <= '0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign out_valid = valid_q;
  assign out_idx   = oidx_q;
  assign out_last  = last_q;
  // Data is selected from the captured pair so a stall needs no extra copy.
  assign out_data  = (state_q == ST_SEND_A) ? a_q :
                     (state_q == ST_SEND_B) ? b_q : '0;

endmodule

// File: tb/tb_ru_dump.sv
// Randomized bench for ru_dump with an RU register-file model and a
// word-level reference model of the dump stream.
module tb_ru_dump;

  logic        clk, rst, start, out_ready;
  logic        busy, done, out_valid, out_last;
  logic [4:0]  rs1, rs2, out_idx;
  logic [31:0] ru_rs1, ru_rs2, out_data;

  logic [31:0] regs [32];
  logic [31:0] exp_words [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ru_dump dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rs1(rs1), .rs2(rs2), .ruRs1(ru_rs1), .ruRs2(ru_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  assign ru_rs1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign ru_rs2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rv(input int i);
    return (i == 0) ? 32'd0 : regs[i];
  endfunction

  // Reference model: idle, one read cycle per pair, one presenting slot per word, done.
  localparam int M_IDLE = 0, M_READ = 1, M_WORD = 2, M_DONE = 3;
  int          m_mode;
  int          m_w;
  logic [31:0] m_snap [32];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_w    <= 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin m_mode <= M_READ; m_w <= 0; end
        M_READ: begin
          m_snap[m_w]     <= rv(m_w);
          m_snap[m_w + 1] <= rv(m_w + 1);
          m_mode <= M_WORD;
        end
        M_WORD: if (out_ready) begin
          if (m_w == 31) m_mode <= M_DONE;
          else begin
            m_w <= m_w + 1;
            if (m_w % 2 == 1) m_mode <= M_READ;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  int          acc_idx [$];
  logic [31:0] acc_dat [$];
  int          stalls;
  bit          done_seen;
  int          done_cyc;
  bit          p_stall;
  logic [31:0] p_data;
  logic [4:0]  p_idx;
  logic        p_last;

  // Per-cycle comparison against the model, stall stability and scoreboard capture.
  always @(negedge clk) begin : cmp
    logic        e_busy, e_done, e_valid, e_last;
    logic [4:0]  e_rs1, e_rs2, e_idx;
    logic [31:0] e_data;
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      e_busy  = (m_mode != M_IDLE);
      e_done  = (m_mode == M_DONE);
      e_rs1   = (m_mode == M_READ) ? 5'(m_w) : 5'd0;
      e_rs2   = (m_mode == M_READ) ? 5'(m_w + 1) : 5'd0;
      e_valid = (m_mode == M_WORD);
      e_data  = e_valid ? m_snap[m_w] : 32'd0;
      e_idx   = e_valid ? 5'(m_w) : 5'd0;
      e_last  = e_valid && (m_w == 31);
      checks++;
      if (busy !== e_busy || done !== e_done || rs1 !== e_rs1 || rs2 !== e_rs2 ||
          out_valid !== e_valid || out_data !== e_data || out_idx !== e_idx || out_last !== e_last) begin
        errors++;
        $display("FAIL cycle cyc=%0d got busy=%b done=%b rs1=%0d rs2=%0d v=%b idx=%0d data=%h last=%b want busy=%b done=%b rs1=%0d rs2=%0d v=%b idx=%0d data=%h last=%b",
                 cyc, busy, done, rs1, rs2, out_valid, out_idx, out_data, out_last,
                 e_busy, e_done, e_rs1, e_rs2, e_valid, e_idx, e_data, e_last);
      end
      if (p_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== p_data || out_idx !== p_idx || out_last !== p_last) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d got v=%b idx=%0d data=%h last=%b want v=1 idx=%0d data=%h last=%b",
                   cyc, out_valid, out_idx, out_data, out_last, p_idx, p_data, p_last);
        end
      end
      if (out_valid && !out_ready) stalls++;
      p_stall = out_valid && !out_ready;
      p_data  = out_data;
      p_idx   = out_idx;
      p_last  = out_last;
      if (out_valid && out_ready) begin
        acc_idx.push_back(int'(out_idx));
        acc_dat.push_back(out_data);
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rs1 !== 5'd0 || rs2 !== 5'd0 || out_valid !== 1'b0 ||
        out_data !== 32'd0 || out_idx !== 5'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b rs1=%0d rs2=%0d v=%b data=%h idx=%0d last=%b want all zero",
               name, busy, done, rs1, rs2, out_valid, out_data, out_idx, out_last);
    end
  endtask

  task automatic exp_from_regs();
    for (int i = 0; i < 32; i++) exp_words[i] = rv(i);
  endtask

  task automatic run_dump(input bit rnd, input int hw, input int hr, input logic [31:0] hv,
                          input int rst_w);
    int c0, n;
    bit hooked, aborted;
    acc_idx.delete();
    acc_dat.delete();
    stalls = 0; done_seen = 1'b0; hooked = 1'b0; aborted = 1'b0; n = 0;
    @(posedge clk); #2 start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2 start = 1'b0; c0 = cyc;
    while (!done_seen && !aborted && n < 600) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = (rnd && (m_mode == M_READ || m_mode == M_WORD) && $urandom_range(0, 7) == 0);
      if (hw >= 0 && !hooked && m_mode == M_WORD && m_w == hw) begin
        regs[hr] = hv;
        hooked = 1'b1;
      end
      if (rst_w >= 0 && m_mode == M_WORD && m_w == rst_w) begin
        rst = 1'b1;
        #1 check_zero("async_reset_outputs");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done got done=%b want 0", done); end
        @(posedge clk); #2 rst = 1'b0;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #2;
        n++;
      end
    end
    start = 1'b0; out_ready = 1'b1;
    if (!aborted) begin
      checks++;
      if (!done_seen) begin errors++; $display("FAIL dump_timeout got no done after %0d cycles want done", n); end
      checks++;
      if (acc_idx.size() != 32) begin errors++; $display("FAIL word_count got %0d want 32", acc_idx.size()); end
      for (int k = 0; k < 32; k++) begin
        checks++;
        if (k >= acc_idx.size()) begin
          errors++; $display("FAIL word_missing idx=%0d got none want %h", k, exp_words[k]);
        end else if (acc_idx[k] != k || acc_dat[k] !== exp_words[k]) begin
          errors++; $display("FAIL word k=%0d got idx=%0d data=%h want idx=%0d data=%h",
                             k, acc_idx[k], acc_dat[k], k, exp_words[k]);
        end
      end
      checks++;
      if (done_cyc != c0 + 48 + stalls) begin
        errors++; $display("FAIL done_time got %0d want %0d (stalls %0d)", done_cyc - c0, 48 + stalls, stalls);
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_dump got busy=%b want 0", busy); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    #1 check_zero("reset_values");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed dump with literal expectations.
    regs[10] = 32'h67676767; regs[8] = 32'h67676760;
    regs[9]  = 32'h67606767; regs[11] = 32'h676C67E7;
    for (int i = 0; i < 32; i++) exp_words[i] = 32'd0;
    exp_words[8]  = 32'h67676760; exp_words[9]  = 32'h67606767;
    exp_words[10] = 32'h67676767; exp_words[11] = 32'h676C67E7;
    run_dump(1'b0, -1, 0, 32'd0, -1);

    // Random contents, random backpressure, spurious start pulses.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      exp_from_regs();
      run_dump(1'b1, -1, 0, 32'd0, -1);
    end

    // Write ahead of the pair read is visible; write after it is not.
    regs[20] = 32'h11111111;
    exp_from_regs();
    exp_words[20] = 32'hDEADBEEF;
    run_dump(1'b0, 4, 20, 32'hDEADBEEF, -1);
    regs[20] = 32'h11111111;
    exp_from_regs();
    run_dump(1'b1, 20, 20, 32'hDEADBEEF, -1);

    // Reset mid-dump, then a clean restart from idx 0.
    run_dump(1'b1, -1, 0, 32'd0, 13);
    exp_from_regs();
    run_dump(1'b1, -1, 0, 32'd0, -1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ru_dump.md
# ru_dump

Sequential reader for the register unit: on a start pulse it walks x0..x31 through the RU's two combinational read ports and streams every register value out over a valid/ready handshake. It sits beside the RU in the single-cycle RISC-V core as a debug/verification dump path. It reads the registers that the writeback path writes, with no write access of its own.

## Interface
- `DW`, 32: data width; must equal the RU's `DataWr` and `ruRs1` width.
- `AW`, 5: register index width; 2**AW registers are dumped and 2**AW must be even.
- `clk`  in  1  : single clock, rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `start`  in  1  : begins a dump; sampled only in IDLE.
- `busy`  out  1  : high in every state except IDLE.
- `done`  out  1  : one-cycle pulse after the last word is accepted.
- `rs1`  out  AW  : RU read address, port 1.
- `rs2`  out  AW  : RU read address, port 2.
- `ruRs1`  in  DW  : RU read data, port 1 (combinational from `rs1`).
- `ruRs2`  in  DW  : RU read data, port 2 (combinational from `rs2`).
- `out_valid`  out  1  : `out_data` and `out_idx` are valid.
- `out_ready`  in  1  : consumer accepts the word when this and `out_valid` are both high at a rising edge.
- `out_data`  out  DW  : register value.
- `out_idx`  out  AW  : register index of `out_data`.
- `out_last`  out  1  : high with index 2**AW-1.

## Operation
- FSM states: IDLE, READ, SEND_A, SEND_B, DONE.
- IDLE:
  - All outputs 0.
  - `start`=1 clears pair index `idx` to 0 and moves to READ.
- READ:
  - Drive `rs1`=`idx` and `rs2`=`idx`+1.
  - At the edge, capture `ruRs1` into `a_q` and `ruRs2` into `b_q`, then go to SEND_A.
  - Exactly one cycle; no handshake.
- SEND_A:
  - `out_valid`=1, `out_data`=`a_q`, `out_idx`=`idx`.
  - Hold until accepted, then go to SEND_B.
- SEND_B:
  - `out_valid`=1, `out_data`=`b_q`, `out_idx`=`idx`+1.
  - `out_last`=1 when `idx`+1 = 2**AW-1.
  - On accept: if last, go to DONE; otherwise `idx`+=2 and go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `rs1`/`rs2` are 0 in every state except READ.
- `start` is ignored while `busy`=1. A `start` held high across DONE→IDLE starts a new dump on the following edge.
- While `out_valid`=1 and `out_ready`=0:
  - `out_data`, `out_idx` and `out_last` stay stable.
  - `out_valid` does not drop.
- Index arithmetic is AW bits. `idx` is always even, and `idx`+1 never wraps inside a dump.
- x0 is read like any other register; the RU returns 0 for it.
- Coherence:
  - Each pair is sampled atomically in its READ cycle.
  - RU writes between pairs show up in later pairs. The dump is not a global snapshot.
- Reset at any time (asynchronous):
  - State goes to IDLE; `idx`, `a_q`, `b_q` clear to 0.
  - All outputs go to 0 immediately, with no `done` pulse.
  - The partial dump is abandoned.

## Timing
- Reset values: `busy`, `done`, `out_valid`, `out_last` = 0; `rs1`, `rs2`, `out_data`, `out_idx` = 0.
- `start` sampled at edge N → READ in cycle N+1, first `out_valid` in cycle N+2.
- With `out_ready` held high:
  - 3 cycles per pair, 48 cycles for 32 registers.
  - Word 31 (`out_last`) is presented in cycle N+48.
  - `done`=1 in cycle N+49; `busy`=0 from cycle N+50.
- Each backpressure cycle adds exactly one cycle of latency.
- The RU read path must settle within the READ cycle, since capture is registered at its end.

## Structure
- Shared package `ru_pkg`:
  - State enum `ru_dump_state_t`.
  - Constants `RU_AW`=5, `RU_DW`=32, `RU_NREGS`=32, reused by the RU and this block.
- Single module. No sub-module: the FSM, pair counter and two capture registers are small enough to sit together.

## Test plan
- Reset, then write x10=0x67676767, x8=0x67676760, x9=0x67606767, x11=0x676C67E7 through the RU; start with `out_ready`=1 → 32 words in index order 0..31. Word 8=0x67676760, word 9=0x67606767, word 10=0x67676767, word 11=0x676C67E7, all others 0; `out_last` only on idx 31; `done` at N+49.
- Random `out_ready` stalls → no word dropped or duplicated; data/idx stable during every stall; completion time = 49 + stall count.
- Pulse `start` again while `busy` → ignored, single dump only.
- RU write to x20=0xDEADBEEF issued while the dump is presenting word 4 → word 20 reads 0xDEADBEEF; an identical write issued after word 20's READ → old value.
- Assert `rst` while presenting word 13 → all outputs 0 in the same cycle, no `done` pulse; a new `start` restarts from idx 0.
- Check `rs1`/`rs2`: they equal (`idx`, `idx`+1) only in READ cycles and 0 otherwise.
